// File: rtl/dp_out_seq.sv
// CPU-side output datapath sequencer: arbitrates register reads against
// DMA FIFO longword writes and drives the lane strobes/enables.
module dp_out_seq #(
   parameter int unsigned TERM_TIMEOUT = 255
) (
   input  logic CLK45,
   input  logic RST,
   input  logic REG_RD,
   input  logic DMA_REQ,
   input  logic PORT16,
   input  logic TERM,
   input  logic ABORT,
   output logic PAS,
   output logic S2CPU,
   output logic F2CPUL,
   output logic F2CPUH,
   output logic BRIDGEOUT,
   output logic DOEH_,
   output logic DOEL_,
   output logic BUS_START,
   output logic FIFO_ACK,
   output logic TO_ERR,
   output logic BUSY
);

   localparam int CW = $clog2(TERM_TIMEOUT + 1);
   localparam logic [CW-1:0] TT_C = CW'(TERM_TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REG,
      ST_LATCH,
      ST_W1,
      ST_W2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic          r_mode16;
   logic          w_mode_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_timeout;
   logic          w_in_drive;
   logic          w_ack_nxt;
   logic          w_to_nxt;
   logic          w_start_nxt;

   logic w_pas;
   logic w_s2cpu;
   logic w_f2l;
   logic w_f2h;
   logic w_bridge;
   logic w_doeh_n;
   logic w_doel_n;

   // r_cnt counts completed drive cycles; the current one makes it w_cnt_inc
   assign w_cnt_inc  = r_cnt + CW'(1);
   assign w_timeout  = (w_cnt_inc == TT_C);
   assign w_in_drive = (r_state == ST_W1) || (r_state == ST_W2);
   assign w_mode_nxt = (r_state == ST_LATCH) ? PORT16 : r_mode16;

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = 1'b0;
      w_to_nxt    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (REG_RD)
               w_state_nxt = ST_REG;
            else if (DMA_REQ && !ABORT)
               w_state_nxt = ST_LATCH;
         end
         ST_REG: begin
            if (!REG_RD)
               w_state_nxt = ST_IDLE;
         end
         ST_LATCH: begin
            if (ABORT)
               w_state_nxt = ST_IDLE;
            else
               w_state_nxt = ST_W1;
         end
         ST_W1: begin
            if (ABORT) begin
               w_state_nxt = ST_IDLE;
            end else if (TERM) begin
               if (r_mode16) begin
                  w_state_nxt = ST_W2;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_ack_nxt   = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_to_nxt    = 1'b1;
            end
         end
         ST_W2: begin
            if (ABORT) begin
               w_state_nxt = ST_IDLE;
            end else if (TERM) begin
               w_state_nxt = ST_IDLE;
               w_ack_nxt   = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_to_nxt    = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_start_nxt = 1'b0;
      w_cnt_nxt   = '0;
      if (w_state_nxt != r_state)
         w_start_nxt = (w_state_nxt == ST_W1) || (w_state_nxt == ST_W2);
      else if (w_in_drive)
         w_cnt_nxt = w_cnt_inc;
   end

   // Moore decode of the state being entered, so outputs leave a flop
   always_comb begin
      w_pas    = 1'b0;
      w_s2cpu  = 1'b0;
      w_f2l    = 1'b0;
      w_f2h    = 1'b0;
      w_bridge = 1'b0;
      w_doeh_n = 1'b1;
      w_doel_n = 1'b1;
      unique case (w_state_nxt)
         ST_REG: w_s2cpu = 1'b1;
         ST_LATCH: w_pas = 1'b1;
         ST_W1: begin
            w_f2h    = 1'b1;
            w_doeh_n = 1'b0;
            if (!w_mode_nxt) begin
               w_f2l    = 1'b1;
               w_doel_n = 1'b0;
            end
         end
         ST_W2: begin
            w_bridge = 1'b1;
            w_doeh_n = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK45) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_mode16  <= 1'b0;
         r_cnt     <= '0;
         PAS       <= 1'b0;
         S2CPU     <= 1'b0;
         F2CPUL    <= 1'b0;
         F2CPUH    <= 1'b0;
         BRIDGEOUT <= 1'b0;
         DOEH_     <= 1'b1;
         DOEL_     <= 1'b1;
         BUS_START <= 1'b0;
         FIFO_ACK  <= 1'b0;
         TO_ERR    <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mode16  <= w_mode_nxt;
         r_cnt     <= w_cnt_nxt;
         PAS       <= w_pas;
         S2CPU     <= w_s2cpu;
         F2CPUL    <= w_f2l;
         F2CPUH    <= w_f2h;
         BRIDGEOUT <= w_bridge;
         DOEH_     <= w_doeh_n;
         DOEL_     <= w_doel_n;
         BUS_START <= w_start_nxt;
         FIFO_ACK  <= w_ack_nxt;
         TO_ERR    <= w_to_nxt;
         BUSY      <= (w_state_nxt != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_dp_out_seq.sv
// Scoreboard bench for dp_out_seq: per-cycle expected output vectors
// queued with the stimulus and compared one clock later.
module tb_dp_out_seq;

   logic CLK45 = 1'b0;
   logic RST, REG_RD, DMA_REQ, PORT16, TERM, ABORT;
   logic PAS, S2CPU, F2CPUL, F2CPUH, BRIDGEOUT;
   logic DOEH_, DOEL_, BUS_START, FIFO_ACK, TO_ERR, BUSY;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK45 = ~CLK45;

   dp_out_seq #(.TERM_TIMEOUT(4)) u_dut (
      .CLK45(CLK45), .RST(RST), .REG_RD(REG_RD), .DMA_REQ(DMA_REQ),
      .PORT16(PORT16), .TERM(TERM), .ABORT(ABORT),
      .PAS(PAS), .S2CPU(S2CPU), .F2CPUL(F2CPUL), .F2CPUH(F2CPUH),
      .BRIDGEOUT(BRIDGEOUT), .DOEH_(DOEH_), .DOEL_(DOEL_),
      .BUS_START(BUS_START), .FIFO_ACK(FIFO_ACK), .TO_ERR(TO_ERR),
      .BUSY(BUSY)
   );

   // {PAS,S2CPU,F2CPUL,F2CPUH,BRIDGEOUT,DOEH_,DOEL_,BUS_START,FIFO_ACK,TO_ERR,BUSY}
   localparam logic [10:0] O_IDLE = 11'b0_0_0_0_0_1_1_0_0_0_0;
   localparam logic [10:0] O_ACK  = 11'b0_0_0_0_0_1_1_0_1_0_0;
   localparam logic [10:0] O_TO   = 11'b0_0_0_0_0_1_1_0_0_1_0;
   localparam logic [10:0] O_REG  = 11'b0_1_0_0_0_1_1_0_0_0_1;
   localparam logic [10:0] O_LAT  = 11'b1_0_0_0_0_1_1_0_0_0_1;
   localparam logic [10:0] O_W32S = 11'b0_0_1_1_0_0_0_1_0_0_1;
   localparam logic [10:0] O_W32  = 11'b0_0_1_1_0_0_0_0_0_0_1;
   localparam logic [10:0] O_W16S = 11'b0_0_0_1_0_0_1_1_0_0_1;
   localparam logic [10:0] O_W16  = 11'b0_0_0_1_0_0_1_0_0_0_1;
   localparam logic [10:0] O_W2S  = 11'b0_0_0_0_1_0_1_1_0_0_1;
   localparam logic [10:0] O_W2   = 11'b0_0_0_0_1_0_1_0_0_0_1;

   typedef struct {
      string       tag;
      logic [10:0] v;
      bit          lchk;
      logic [15:0] lane;
   } exp_t;

   exp_t sb_q[$];

   // Tiny model of the output datapath: OD latched on PAS, upper lanes muxed
   logic [31:0] tb_od = 32'h1234_5678;
   logic [31:0] od_lat = '0;
   logic [15:0] up_lanes;

   always @(posedge PAS) od_lat <= tb_od;

   assign up_lanes = F2CPUH    ? od_lat[31:16] :
                     BRIDGEOUT ? od_lat[15:0]  : 16'h0000;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge CLK45) begin
      #1;
      if (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check(e.tag, 32'({PAS, S2CPU, F2CPUL, F2CPUH, BRIDGEOUT, DOEH_,
                           DOEL_, BUS_START, FIFO_ACK, TO_ERR, BUSY}),
               32'(e.v));
         if (e.lchk)
            check({e.tag, "_lane"}, 32'(up_lanes), 32'(e.lane));
      end
   end

   // Drive one cycle of inputs; exp is the output vector for the next cycle
   task automatic cyc(input string tag, input logic rst, input logic rr,
                      input logic dma, input logic p16, input logic term,
                      input logic abt, input logic [10:0] exp,
                      input bit lchk = 1'b0,
                      input logic [15:0] lane = 16'h0);
      exp_t e;
      @(negedge CLK45);
      RST = rst; REG_RD = rr; DMA_REQ = dma;
      PORT16 = p16; TERM = term; ABORT = abt;
      e.tag = tag; e.v = exp; e.lchk = lchk; e.lane = lane;
      sb_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; REG_RD = 1'b0; DMA_REQ = 1'b0;
      PORT16 = 1'b0; TERM = 1'b0; ABORT = 1'b0;

      cyc("rst0", 1, 0, 0, 0, 0, 0, O_IDLE);
      cyc("rst1", 1, 0, 1, 0, 0, 0, O_IDLE);
      cyc("idle", 0, 0, 0, 0, 1, 0, O_IDLE);

      // 32-bit transfer, TERM on third W1 cycle
      cyc("d32_lat", 0, 0, 1, 0, 0, 0, O_LAT);
      cyc("d32_w1a", 0, 0, 0, 0, 0, 0, O_W32S);
      cyc("d32_w1b", 0, 0, 0, 0, 0, 0, O_W32);
      cyc("d32_w1c", 0, 0, 0, 0, 0, 0, O_W32);
      cyc("d32_ack", 0, 0, 0, 0, 1, 0, O_ACK);
      cyc("d32_idl", 0, 0, 0, 0, 0, 0, O_IDLE);

      // 16-bit transfer with lane data check
      cyc("d16_lat", 0, 0, 1, 1, 0, 0, O_LAT);
      cyc("d16_w1",  0, 0, 0, 1, 0, 0, O_W16S, 1'b1, 16'h1234);
      cyc("d16_w2s", 0, 0, 0, 0, 1, 0, O_W2S,  1'b1, 16'h5678);
      cyc("d16_w2",  0, 0, 0, 0, 0, 0, O_W2,   1'b1, 16'h5678);
      cyc("d16_ack", 0, 0, 0, 0, 1, 0, O_ACK);
      cyc("d16_idl", 0, 0, 0, 0, 0, 0, O_IDLE);

      // arbitration: REG beats DMA; REG_RD ignored during a transfer
      cyc("arb_reg", 0, 1, 1, 0, 1, 0, O_REG);
      cyc("arb_hold", 0, 1, 1, 0, 0, 0, O_REG);
      cyc("arb_rel", 0, 0, 0, 0, 0, 0, O_IDLE);
      cyc("arb_lat", 0, 0, 1, 0, 0, 0, O_LAT);
      cyc("arb_w1",  0, 1, 0, 0, 0, 0, O_W32S);
      cyc("arb_ack", 0, 1, 0, 0, 1, 0, O_ACK);
      cyc("arb_reg2", 0, 1, 1, 0, 0, 0, O_REG);
      cyc("arb_idl", 0, 0, 0, 0, 0, 0, O_IDLE);

      // timeout after 4 W1 cycles
      cyc("to_lat", 0, 0, 1, 0, 0, 0, O_LAT);
      cyc("to_w1a", 0, 0, 0, 0, 0, 0, O_W32S);
      cyc("to_w1b", 0, 0, 0, 0, 0, 0, O_W32);
      cyc("to_w1c", 0, 0, 0, 0, 0, 0, O_W32);
      cyc("to_w1d", 0, 0, 0, 0, 0, 0, O_W32);
      cyc("to_err", 0, 0, 0, 0, 0, 0, O_TO);
      cyc("to_idl", 0, 0, 0, 0, 0, 0, O_IDLE);

      // TERM on the timeout cycle wins
      cyc("tw_lat", 0, 0, 1, 0, 0, 0, O_LAT);
      cyc("tw_w1a", 0, 0, 0, 0, 0, 0, O_W32S);
      cyc("tw_w1b", 0, 0, 0, 0, 0, 0, O_W32);
      cyc("tw_w1c", 0, 0, 0, 0, 0, 0, O_W32);
      cyc("tw_w1d", 0, 0, 0, 0, 0, 0, O_W32);
      cyc("tw_ack", 0, 0, 0, 0, 1, 0, O_ACK);

      // timeout in W2
      cyc("t2_lat", 0, 0, 1, 1, 0, 0, O_LAT);
      cyc("t2_w1",  0, 0, 0, 1, 0, 0, O_W16S);
      cyc("t2_w2s", 0, 0, 0, 0, 1, 0, O_W2S);
      cyc("t2_w2b", 0, 0, 0, 0, 0, 0, O_W2);
      cyc("t2_w2c", 0, 0, 0, 0, 0, 0, O_W2);
      cyc("t2_w2d", 0, 0, 0, 0, 0, 0, O_W2);
      cyc("t2_err", 0, 0, 0, 0, 0, 0, O_TO);

      // ABORT in LATCH, in W2 (beats TERM), and held in IDLE
      cyc("ab_lat", 0, 0, 1, 0, 0, 0, O_LAT);
      cyc("ab_l_idl", 0, 0, 0, 0, 0, 1, O_IDLE);
      cyc("ab_lat2", 0, 0, 1, 1, 0, 0, O_LAT);
      cyc("ab_w1",  0, 0, 0, 1, 0, 0, O_W16S);
      cyc("ab_w2",  0, 0, 0, 0, 1, 0, O_W2S);
      cyc("ab_w2_idl", 0, 0, 0, 0, 1, 1, O_IDLE);
      cyc("ab_hold1", 0, 0, 1, 0, 0, 1, O_IDLE);
      cyc("ab_hold2", 0, 0, 1, 0, 0, 1, O_IDLE);
      cyc("ab_rel", 0, 0, 0, 0, 0, 0, O_IDLE);

      // reset mid-W2, then a clean 32-bit transfer
      cyc("rw_lat", 0, 0, 1, 1, 0, 0, O_LAT);
      cyc("rw_w1",  0, 0, 0, 1, 0, 0, O_W16S);
      cyc("rw_w2",  0, 0, 0, 0, 1, 0, O_W2S);
      cyc("rw_rst", 1, 0, 0, 0, 0, 0, O_IDLE);
      cyc("rw_idl", 0, 0, 0, 0, 0, 0, O_IDLE);
      cyc("rw_lat2", 0, 0, 1, 0, 0, 0, O_LAT);
      cyc("rw_w1b", 0, 0, 0, 0, 0, 0, O_W32S);
      cyc("rw_ack", 0, 0, 0, 0, 1, 0, O_ACK);
      cyc("rw_end", 0, 0, 0, 0, 0, 0, O_IDLE);

      @(posedge CLK45);
      #2;
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dp_out_seq.md
# dp_out_seq

Sequencer for the CPU-side output datapath. It decides each cycle whether the data bus is driven from the register-read path (S2CPU) or from the FIFO longword latches (F2CPU). It generates the latch strobe PAS, lane enables DOEH_/DOEL_, lane selects F2CPUL/F2CPUH and BRIDGEOUT, including the two-word split for 16-bit ports. It sits between the DMA bus-master state machine, the register-access decoder and the output datapath, and arbitrates between register reads and DMA FIFO writes.

## Interface
Parameters:
- TERM_TIMEOUT, 255: maximum cycles a drive state waits for TERM before giving up (legal range 1..4095).

Ports:
- CLK45  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous active-high reset.
- REG_RD  in  1  level; CPU slave read of an internal register is in progress.
- DMA_REQ  in  1  level; FIFO holds a longword to be written to memory.
- PORT16  in  1  target memory port is 16 bits wide; sampled in LATCH only.
- TERM  in  1  one-cycle pulse, synchronised bus-cycle termination (DSACK/STERM).
- ABORT  in  1  level; DMA abort request.
- PAS  out  1  FIFO output latch strobe; datapath latches OD on its rising edge.
- S2CPU  out  1  drive register data MOD onto all 32 lanes.
- F2CPUL  out  1  lower lanes take the latched lower word.
- F2CPUH  out  1  upper lanes take the latched upper word.
- BRIDGEOUT  out  1  route the latched lower word to the upper lanes.
- DOEH_  out  1  active-low upper-lane output enable.
- DOEL_  out  1  active-low lower-lane output enable.
- BUS_START  out  1  one-cycle pulse; requests a bus cycle from the bus-master FSM.
- FIFO_ACK  out  1  one-cycle pulse; the current longword has been fully written.
- TO_ERR  out  1  one-cycle pulse; TERM timeout occurred.
- BUSY  out  1  high whenever the state is not IDLE.

## Operation
- All outputs are registered and depend on the state only (Moore outputs).
- States: IDLE, REG, LATCH, W1, W2.
- IDLE: no lane driven. If REG_RD=1, go to REG. Else if DMA_REQ=1 and ABORT=0, go to LATCH. REG_RD beats DMA_REQ when both are asserted.
- REG: S2CPU=1 and DOEH_/DOEL_=1. Stay while REG_RD=1; go to IDLE when REG_RD=0.
- LATCH: PAS=1 for exactly one cycle. Capture PORT16 into a mode register, then go to W1.
- W1, 32-bit mode: F2CPUL=F2CPUH=1, DOEH_=DOEL_=0.
- W1, 16-bit mode: F2CPUH=1, BRIDGEOUT=0, DOEH_=0, DOEL_=1.
- W1 exit on TERM:
  - 32-bit mode: go to IDLE and pulse FIFO_ACK.
  - 16-bit mode: go to W2.
- W2: F2CPUH=0, F2CPUL=0, BRIDGEOUT=1, DOEH_=0, DOEL_=1, so the lower word goes out on the upper lanes. On TERM, go to IDLE and pulse FIFO_ACK.
- BUS_START: pulses in the first cycle of every W1 and every W2 entry.
- Timeout counter: width clog2(TERM_TIMEOUT+1).
  - Cleared on entry to W1 and to W2; increments each cycle in those states.
  - When it equals TERM_TIMEOUT with no TERM: pulse TO_ERR and go to IDLE. No FIFO_ACK; the longword stays in the FIFO.
- Abort: ABORT=1 in LATCH, W1 or W2 forces IDLE on the next edge, with no FIFO_ACK and no TO_ERR.
- Non-preemption: a DMA transfer (LATCH through W2) is never preempted by REG_RD. REG_RD waits until IDLE.
- Turnaround: after any exit to IDLE, at least one IDLE cycle follows with all enables high before any new drive.

## Timing
- Reset values (RST=1 on an edge): state IDLE; PAS=0, S2CPU=0, F2CPUL=F2CPUH=0, BRIDGEOUT=0, DOEH_=DOEL_=1, BUS_START=FIFO_ACK=TO_ERR=0, BUSY=0; counter and mode register cleared. This applies mid-transfer as well.
- DMA_REQ sampled high at edge n (in IDLE): LATCH/PAS=1 in cycle n+1; W1 and BUS_START in cycle n+2.
- TERM sampled at edge m in W1 (32-bit): IDLE and FIFO_ACK=1 in cycle m+1. Minimum 32-bit transfer is 4 cycles including the return IDLE.
- 16-bit transfer: TERM at edge m in W1 gives W2 and BUS_START in cycle m+1. TERM in W2 gives FIFO_ACK in the next cycle.
- TERM in the first cycle of W1 or W2 is legal and is honoured.
- TERM in IDLE, REG or LATCH is ignored.
- TERM and the timeout reached on the same cycle: TERM wins (normal completion, no TO_ERR).
- ABORT and TERM on the same cycle: ABORT wins (no FIFO_ACK).
- REG_RD deassert at edge k: S2CPU=0 in cycle k+1.

## Test plan
- Reset mid-W2 (16-bit): assert RST for 1 cycle -> next cycle all outputs at reset values; DOEH_=DOEL_=1.
- 32-bit DMA: DMA_REQ=1, PORT16=0, TERM 3 cycles after W1 entry -> PAS 1 cycle, W1 with F2CPUL=F2CPUH=1 and DOEH_=DOEL_=0 for 3 cycles, exactly one BUS_START, FIFO_ACK one cycle after TERM.
- 16-bit DMA with OD=32'h1234_5678 latched: drive cycle 1 has upper lanes = 16'h1234 (F2CPUH=1, DOEL_=1). After the first TERM, upper lanes = 16'h5678 (BRIDGEOUT=1). Two BUS_START pulses, one FIFO_ACK.
- Arbitration: REG_RD and DMA_REQ rise together -> REG first (S2CPU=1). REG_RD asserted during W1 -> ignored until IDLE; DMA completes first, then REG is entered.
- Timeout with TERM_TIMEOUT=4, no TERM -> TO_ERR after exactly 4 W1 cycles, then IDLE, no FIFO_ACK. Repeat with TERM on the 4th cycle -> FIFO_ACK, no TO_ERR.
- ABORT in LATCH and again in W2 -> IDLE next cycle, no FIFO_ACK. ABORT held in IDLE with DMA_REQ=1 -> stays IDLE.
